// File: rtl/mux_pkg.sv
// Shared constants for the arbitrated N-channel selector.
// Mode encodings and default sizing.
package mux_pkg;

  localparam logic [1:0] MODO_MANUAL = 2'b00;
  localparam logic [1:0] MODO_PRIO   = 2'b01;
  localparam logic [1:0] MODO_RR     = 2'b10;
  localparam logic [1:0] MODO_RES    = 2'b11;

  localparam int LARGURA_PADRAO = 32;
  localparam int CANAIS_PADRAO  = 4;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational rotating arbiter: first request at or after ptr wins.
// With ptr forced to 0 it degenerates into a fixed-priority arbiter.
module arbitro_rr #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  // scan channels ptr, ptr+1, ... modulo N and keep the first hit
  always_comb begin
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx      = PW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_arbitrado.sv
// N-channel valid/ready selector with manual, priority and
// round-robin arbitration feeding a one-entry output register.
module mux_n_arbitrado
  import mux_pkg::*;
#(
  parameter  int LARGURA = LARGURA_PADRAO,
  parameter  int CANAIS  = CANAIS_PADRAO,
  localparam int SEL_W   = $clog2(CANAIS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                modo,
  input  logic [SEL_W-1:0]          controle,
  input  logic [CANAIS*LARGURA-1:0] entrada_dados,
  input  logic [CANAIS-1:0]         entrada_valido,
  output logic [CANAIS-1:0]         entrada_pronto,
  output logic [LARGURA-1:0]        saida_dados,
  output logic                      saida_valido,
  input  logic                      saida_pronto,
  output logic [SEL_W-1:0]          canal_sel
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_arb;
  logic [SEL_W-1:0]  idx_arb;
  logic [SEL_W-1:0]  k;
  logic [SEL_W-1:0]  ptr_prox;
  logic [CANAIS-1:0] grant_arb;
  logic [CANAIS-1:0] grant;
  logic              carga;
  logic              transfer;
  logic [LARGURA-1:0] palavra;

  // only round-robin rotates; every other mode scans from channel 0
  always_comb begin
    ptr_arb = '0;
    if (modo == MODO_RR) ptr_arb = ptr;
  end

  arbitro_rr #(
    .N  (CANAIS),
    .PW (SEL_W)
  ) u_arb (
    .req   (entrada_valido),
    .ptr   (ptr_arb),
    .grant (grant_arb),
    .idx   (idx_arb)
  );

  // manual mode bypasses the arbiter; out-of-range index grants nothing
  always_comb begin
    grant = '0;
    k     = idx_arb;
    if (modo == MODO_MANUAL) begin
      k = controle;
      if (int'(controle) < CANAIS)
        grant[controle] = entrada_valido[controle];
    end else begin
      grant = grant_arb;
    end
  end

  // handshake: accept only when the output slot is free or draining
  always_comb begin
    carga          = !saida_valido || saida_pronto;
    entrada_pronto = '0;
    if (carga && !reset) entrada_pronto = grant;
    transfer = |entrada_pronto;
    palavra  = entrada_dados[int'(k)*LARGURA +: LARGURA];
    ptr_prox = (int'(k) == CANAIS - 1) ? '0 : k + SEL_W'(1);
  end

  // output register and round-robin pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida_dados  <= '0;
      saida_valido <= 1'b0;
      canal_sel    <= '0;
      ptr          <= '0;
    end else if (transfer) begin
      saida_dados  <= palavra;
      saida_valido <= 1'b1;
      canal_sel    <= k;
      if (modo == MODO_RR) ptr <= ptr_prox;
    end else if (saida_pronto) begin
      saida_valido <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_arbitrado.sv
// Randomized and directed bench for mux_n_arbitrado,
// checked against a behavioural model of the arbitration rules.
module tb_mux_n_arbitrado;

  localparam int LA = 32;
  localparam int NA = 4;
  localparam int LB = 8;
  localparam int NB = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0]     modo_a;
  logic [1:0]     ctrl_a;
  logic [NA*LA-1:0] dados_a;
  logic [NA-1:0]  valido_a;
  logic [NA-1:0]  pronto_a;
  logic [LA-1:0]  sdados_a;
  logic           svalido_a;
  logic           spronto_a;
  logic [1:0]     canal_a;

  logic [1:0]     modo_b;
  logic [1:0]     ctrl_b;
  logic [NB*LB-1:0] dados_b;
  logic [NB-1:0]  valido_b;
  logic [NB-1:0]  pronto_b;
  logic [LB-1:0]  sdados_b;
  logic           svalido_b;
  logic           spronto_b;
  logic [1:0]     canal_b;

  mux_n_arbitrado #(.LARGURA(LA), .CANAIS(NA)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .modo           (modo_a),
    .controle       (ctrl_a),
    .entrada_dados  (dados_a),
    .entrada_valido (valido_a),
    .entrada_pronto (pronto_a),
    .saida_dados    (sdados_a),
    .saida_valido   (svalido_a),
    .saida_pronto   (spronto_a),
    .canal_sel      (canal_a)
  );

  mux_n_arbitrado #(.LARGURA(LB), .CANAIS(NB)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .modo           (modo_b),
    .controle       (ctrl_b),
    .entrada_dados  (dados_b),
    .entrada_valido (valido_b),
    .entrada_pronto (pronto_b),
    .saida_dados    (sdados_b),
    .saida_valido   (svalido_b),
    .saida_pronto   (spronto_b),
    .canal_sel      (canal_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // winner per the mode rules, -1 when nobody is granted
  function automatic int pick(input int n, input logic [1:0] modo,
                              input int ctrl, input logic [15:0] v,
                              input int ptr);
    int s;
    if (modo == 2'b00) return (ctrl < n && v[ctrl]) ? ctrl : -1;
    s = (modo == 2'b10) ? ptr : 0;
    for (int i = 0; i < n; i++)
      if (v[(s + i) % n]) return (s + i) % n;
    return -1;
  endfunction

  bit          mv;
  logic [31:0] md;
  int          mc;
  int          mp;

  task automatic model_reset();
    mv = 1'b0;
    md = '0;
    mc = 0;
    mp = 0;
  endtask

  // one clock of channel set A: inputs already driven at posedge+1
  task automatic cyc_a();
    int         k;
    bit         carga;
    logic [3:0] ep;
    #1;
    carga = !mv || spronto_a;
    k = carga ? pick(NA, modo_a, int'(ctrl_a), 16'(valido_a), mp) : -1;
    ep = (k >= 0) ? 4'(1 << k) : 4'b0;
    check("pronto_a", 64'(pronto_a), 64'(ep));
    if (k >= 0) begin
      mv = 1'b1;
      md = dados_a[k*LA +: LA];
      mc = k;
      if (modo_a == 2'b10) mp = (k + 1) % NA;
    end else if (spronto_a) begin
      mv = 1'b0;
    end
    @(posedge clock);
    #1;
    check("valido_a", 64'(svalido_a), 64'(mv));
    check("dados_a", 64'(sdados_a), 64'(md));
    check("canal_a", 64'(canal_a), 64'(mc));
  endtask

  task automatic reset_all();
    reset     = 1'b1;
    valido_a  = '0;
    valido_b  = '0;
    spronto_a = 1'b1;
    spronto_b = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valido", 64'(svalido_a), 64'd0);
    check("rst_dados", 64'(sdados_a), 64'd0);
    check("rst_canal", 64'(canal_a), 64'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int seq [6];
    int sb [4];
    seq = '{0, 1, 2, 3, 0, 1};
    sb  = '{0, 1, 2, 0};
    reset    = 1'b1;
    modo_a   = 2'b01;
    ctrl_a   = '0;
    dados_a  = '0;
    valido_a = 4'b1111;
    spronto_a = 1'b1;
    modo_b   = 2'b10;
    ctrl_b   = '0;
    dados_b  = '0;
    valido_b = '0;
    spronto_b = 1'b1;
    #2;
    check("rst_pronto_gated", 64'(pronto_a), 64'd0);
    reset_all();

    // fixed priority picks lowest valid
    modo_a   = 2'b01;
    valido_a = 4'b1010;
    dados_a  = {32'h33333333, 32'h0, 32'h11111111, 32'h0};
    cyc_a();
    check("prio_dados", 64'(sdados_a), 64'h11111111);
    check("prio_canal", 64'(canal_a), 64'd1);

    // round-robin rotation without bubbles
    reset_all();
    modo_a   = 2'b10;
    valido_a = 4'b1111;
    dados_a  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    for (int i = 0; i < 6; i++) begin
      cyc_a();
      check("rr_seq", 64'(canal_a), 64'(seq[i]));
      check("rr_nobubble", 64'(svalido_a), 64'd1);
    end

    // manual mode ignores other channels
    reset_all();
    modo_a   = 2'b00;
    ctrl_a   = 2'd2;
    valido_a = 4'b0011;
    cyc_a();
    cyc_a();
    check("man_idle", 64'(svalido_a), 64'd0);
    valido_a = 4'b0111;
    dados_a[2*LA +: LA] = 32'hCAFEBABE;
    cyc_a();
    check("man_dados", 64'(sdados_a), 64'hCAFEBABE);
    check("man_canal", 64'(canal_a), 64'd2);

    // backpressure holds the output word
    modo_a   = 2'b01;
    valido_a = 4'b0001;
    dados_a[0 +: LA] = 32'hAAAA0000;
    cyc_a();
    spronto_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valido_a = 4'($urandom_range(15));
      dados_a  = {$urandom, $urandom, $urandom, $urandom};
      modo_a   = 2'($urandom_range(3));
      cyc_a();
      check("bp_hold", 64'(sdados_a), 64'hAAAA0000);
    end
    spronto_a = 1'b1;
    modo_a    = 2'b01;
    valido_a  = 4'b0001;
    dados_a[0 +: LA] = 32'h12345678;
    cyc_a();
    check("bp_reload", 64'(sdados_a), 64'h12345678);

    // asynchronous reset mid-cycle
    #3;
    reset = 1'b1;
    #1;
    check("arst_valido", 64'(svalido_a), 64'd0);
    check("arst_dados", 64'(sdados_a), 64'd0);
    check("arst_pronto", 64'(pronto_a), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    modo_a   = 2'b10;
    valido_a = 4'b1111;
    cyc_a();
    check("arst_first_ch0", 64'(canal_a), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      modo_a    = 2'($urandom_range(3));
      ctrl_a    = 2'($urandom_range(3));
      valido_a  = 4'($urandom_range(15));
      dados_a   = {$urandom, $urandom, $urandom, $urandom};
      spronto_a = ($urandom_range(3) != 0);
      cyc_a();
    end

    // three-channel instance: wrap and out-of-range manual index
    reset_all();
    valido_a = '0;
    modo_b   = 2'b10;
    valido_b = 3'b111;
    dados_b  = {8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      check("b_rr_canal", 64'(canal_b), 64'(sb[i]));
      check("b_rr_dados", 64'(sdados_b), 64'(8'hA0 + sb[i]));
    end
    modo_b = 2'b00;
    ctrl_b = 2'd3;
    #1;
    check("b_oor_pronto", 64'(pronto_b), 64'd0);
    @(posedge clock);
    #1;
    check("b_oor_valido", 64'(svalido_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
